shift_issue_buf: RTL and testbench
==================================

Name: shift_issue_buf

Overview:
- Execute-stage operand issue buffer that sits directly upstream of the 16-bit barrel shifter and feeds its In/Cnt/Op inputs.
- Accepts shift requests from decode over a valid/ready handshake and resolves the shift count from either a register or an immediate.
- Applies logical-shift saturation, then holds requests in a small FIFO so a shifter-side stall never drops an operation.
- Supports synchronous flush for branch mispredict.

Parameters:
WIDTH, 16, data width; fixed to match the shifter, other values unsupported.
DEPTH, 2, FIFO entries; power of two, >= 2.
SAT_SHIFT, 1, when 1, logical shifts by a register count > 15 produce zero.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  discard all buffered and incoming requests
in_valid  input  1  request valid from decode
in_ready  output  1  buffer can accept request
in_data  input  16  operand to shift
in_op  input  2  00 rotate left, 01 shift left, 10 rotate right, 11 shift right
in_imm_sel  input  1  1 = count from in_imm, 0 = from in_reg_cnt
in_imm  input  4  immediate shift count
in_reg_cnt  input  16  register-sourced shift count
out_valid  output  1  head entry valid to shifter stage
out_ready  input  1  shifter stage consumes head
out_data  output  16  to shifter In
out_cnt  output  4  to shifter Cnt
out_op  output  2  to shifter Op
out_sat  output  1  head entry was saturated (diagnostic/flag path)
level  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n=0 at clock edge):
  - Occupancy 0; read/write pointers 0; all entries cleared.
  - out_valid=0; out_data/out_cnt/out_op/out_sat=0; level=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Reset mid-operation discards all entries; there is no partial retention.
- Push: in_valid && in_ready at a rising edge writes one entry.
- Pop: out_valid && out_ready at a rising edge removes the head.
- in_ready = (level < DEPTH). It is combinational from registered occupancy and does not depend on out_ready; there is no pass-through when full.
- Latency: a request pushed into an empty buffer appears with out_valid=1 in the next cycle. There is no combinational in->out path.
- Simultaneous push and pop with 0 < level < DEPTH: both occur and level is unchanged. When level == DEPTH, no push can occur.
- out_* are driven from the head entry when level > 0 and are all-zero when level == 0.
- Once out_valid=1, out_data/out_cnt/out_op/out_sat are held stable until popped or flushed.
- Pointers wrap modulo DEPTH.
- Count resolution at push:
  - raw = in_imm_sel ? in_imm : in_reg_cnt[3:0].
  - sat = SAT_SHIFT && !in_imm_sel && in_op[0]==1 && in_reg_cnt[15:4] != 0.
  - If sat: the stored data is 0, cnt is 0, op is in_op, and sat=1. Otherwise: data=in_data, cnt=raw, op=in_op, sat=0.
  - Rotates always use the count modulo 16 (upper register bits ignored, sat=0).
- Flush has highest priority:
  - flush=1 at an edge sets level=0 and pointers=0, so out_valid=0 next cycle.
  - Any push or pop in the same cycle is ignored; a concurrent in_valid is dropped even though in_ready was 1.
  - in_ready is 1 the cycle after flush.
- out_valid = (level != 0).
- level is exact and never exceeds DEPTH or underflows.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Response: during reset out_valid=0, in_ready=0, level=0. First cycle after release: in_ready=1, out_*=0.
- Single request:
  - Stimulus: push in_data=16'h8001, in_op=00, in_imm_sel=1, in_imm=4'd1 with out_ready=1.
  - Response: next cycle out_valid=1, out_data=16'h8001, out_cnt=1, out_op=00, out_sat=0, level=1. The following cycle out_valid=0.
- Backpressure/full:
  - Stimulus: out_ready=0; push A=16'h1111 and B=16'h2222.
  - Response: level=2, in_ready=0, and a held third request C=16'h3333 is not accepted.
  - Stimulus: raise out_ready.
  - Response: pops occur in order A, B, C (C accepted once in_ready=1); out_data stays stable while stalled.
- Saturation:
  - Stimulus: in_op=11, in_imm_sel=0, in_reg_cnt=16'h0013, in_data=16'hFFFF.
  - Response: out_data=0, out_cnt=0, out_sat=1.
  - Stimulus: same count with in_op=10.
  - Response: out_data=16'hFFFF, out_cnt=3, out_sat=0.
  - Stimulus: in_reg_cnt=16'h0005, in_op=01.
  - Response: out_cnt=5, out_sat=0.
- Flush:
  - Stimulus: level=2, and on the flush cycle in_valid=1 and out_ready=1.
  - Response: next cycle level=0, out_valid=0, and the incoming request is absent afterwards.
  - Stimulus: reassert rst_n=0 with level=1.
  - Response: same result as flush; next push appears normally.
- Concurrent push/pop:
  - Stimulus: level=1 steady, push and pop every cycle for 8 cycles.
  - Response: level stays 1; pointers wrap; outputs emerge in order with 1-cycle buffering.

Source files
------------

// File: rtl/shift_issue_buf.sv
// rtl/shift_issue_buf.sv - operand issue FIFO feeding the 16-bit barrel shifter
module shift_issue_buf #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 2,
    parameter int SAT_SHIFT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 in_op,
    input  logic                       in_imm_sel,
    input  logic [3:0]                 in_imm,
    input  logic [15:0]                in_reg_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [3:0]                 out_cnt,
    output logic [1:0]                 out_op,
    output logic                       out_sat,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [3:0]       cnt_q  [DEPTH];
    logic [3:0]       cnt_d  [DEPTH];
    logic [1:0]       op_q   [DEPTH];
    logic [1:0]       op_d   [DEPTH];
    logic             sat_q  [DEPTH];
    logic             sat_d  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic       push;
    logic       pop;
    logic       sat_req;
    logic [3:0] raw_cnt;

    // in_ready is forced low while reset is held so decode never pushes into a clearing buffer
    assign in_ready  = rst_n && (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign level     = level_q;

    assign out_data = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_cnt  = out_valid ? cnt_q[rd_ptr_q]  : '0;
    assign out_op   = out_valid ? op_q[rd_ptr_q]   : '0;
    assign out_sat  = out_valid ? sat_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready && !flush;
        raw_cnt = in_imm_sel ? in_imm : in_reg_cnt[3:0];
        // Only logical shifts (op[0]=1) by a register count saturate; rotates wrap mod 16
        sat_req = (SAT_SHIFT != 0) && !in_imm_sel && in_op[0] && (in_reg_cnt[15:4] != '0);

        data_d   = data_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sat_d    = sat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = sat_req ? '0 : in_data;
                cnt_d[wr_ptr_q]  = sat_req ? 4'd0 : raw_cnt;
                op_d[wr_ptr_q]   = in_op;
                sat_d[wr_ptr_q]  = sat_req;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
                op_q[i]   <= '0;
                sat_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sat_q    <= sat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_shift_issue_buf.sv
// tb/tb_shift_issue_buf.sv - directed self-checking bench for shift_issue_buf
module tb_shift_issue_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_op;
    logic        in_imm_sel;
    logic [3:0]  in_imm;
    logic [15:0] in_reg_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_cnt;
    logic [1:0]  out_op;
    logic        out_sat;
    logic [1:0]  level;

    int checks = 0;
    int errors = 0;

    shift_issue_buf #(.WIDTH(16), .DEPTH(2), .SAT_SHIFT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .in_reg_cnt (in_reg_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .out_op     (out_op),
        .out_sat    (out_sat),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [1:0] op, input logic sel,
                         input logic [3:0] imm, input logic [15:0] reg_cnt);
        in_valid   = 1'b1;
        in_data    = d;
        in_op      = op;
        in_imm_sel = sel;
        in_imm     = imm;
        in_reg_cnt = reg_cnt;
    endtask

    // Packed view of outputs: {out_valid, out_data, out_cnt, out_op, out_sat, level}
    function automatic logic [25:0] obs();
        return {out_valid, out_data, out_cnt, out_op, out_sat, level};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({out_valid, in_ready, level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold valid/ready/level got %b want 0000", {out_valid, in_ready, level});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        checks++;
        if (obs() !== 26'h0) begin
            errors++;
            $display("FAIL reset_release_outputs got %h want 0", obs());
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(16'h8001, 2'b00, 1'b1, 4'd1, 16'h0000);
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== {1'b1, 16'h8001, 4'd1, 2'b00, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL single_out got %h want %h", obs(), {1'b1, 16'h8001, 4'd1, 2'b00, 1'b0, 2'd1});
        end
        tick();
        checks++;
        if ({out_valid, level} !== 3'b000) begin
            errors++;
            $display("FAIL single_drain got %b want 000", {out_valid, level});
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        drive(16'h1111, 2'b01, 1'b1, 4'd2, 16'h0000);
        tick();
        drive(16'h2222, 2'b01, 1'b1, 4'd2, 16'h0000);
        tick();
        checks++;
        if ({level, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL full_level_ready got %b want 100", {level, in_ready});
        end
        drive(16'h3333, 2'b01, 1'b1, 4'd2, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({level, out_data} !== {2'd2, 16'h1111}) begin
                errors++;
                $display("FAIL full_stall_%0d got %h want %h", i, {level, out_data}, {2'd2, 16'h1111});
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({level, out_data, in_ready} !== {2'd1, 16'h2222, 1'b1}) begin
            errors++;
            $display("FAIL full_pop_a got %h want %h", {level, out_data, in_ready}, {2'd1, 16'h2222, 1'b1});
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({level, out_data} !== {2'd1, 16'h3333}) begin
            errors++;
            $display("FAIL full_pop_b got %h want %h", {level, out_data}, {2'd1, 16'h3333});
        end
        tick();
        checks++;
        if ({out_valid, level} !== 3'b000) begin
            errors++;
            $display("FAIL full_drain got %b want 000", {out_valid, level});
        end
    endtask

    task automatic test_saturation();
        logic [15:0] v_data [4] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'hABCD};
        logic [1:0]  v_op   [4] = '{2'b11, 2'b10, 2'b01, 2'b11};
        logic        v_sel  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  v_imm  [4] = '{4'd0, 4'd0, 4'd0, 4'd7};
        logic [15:0] v_reg  [4] = '{16'h0013, 16'h0013, 16'h0005, 16'hFFFF};
        logic [15:0] e_data [4] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hABCD};
        logic [3:0]  e_cnt  [4] = '{4'd0, 4'd3, 4'd5, 4'd7};
        logic        e_sat  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(v_data[i], v_op[i], v_sel[i], v_imm[i], v_reg[i]);
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs() !== {1'b1, e_data[i], e_cnt[i], v_op[i], e_sat[i], 2'd1}) begin
                errors++;
                $display("FAIL sat_vec_%0d got %h want %h", i, obs(),
                         {1'b1, e_data[i], e_cnt[i], v_op[i], e_sat[i], 2'd1});
            end
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(16'hAAAA, 2'b00, 1'b1, 4'd1, 16'h0000);
        tick();
        drive(16'hBBBB, 2'b00, 1'b1, 4'd1, 16'h0000);
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(16'hCCCC, 2'b00, 1'b1, 4'd1, 16'h0000);
        checks++;
        if (level !== 2'd2) begin
            errors++;
            $display("FAIL flush_prefill got %0d want 2", level);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, level, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL flush_clear got %b want 0001", {out_valid, level, in_ready});
        end
        tick();
        checks++;
        if (obs() !== 26'h0) begin
            errors++;
            $display("FAIL flush_dropped got %h want 0", obs());
        end
        out_ready = 1'b0;
        drive(16'hDDDD, 2'b00, 1'b1, 4'd1, 16'h0000);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        checks++;
        if ({out_valid, level, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_clear got %b want 0000", {out_valid, level, in_ready});
        end
        rst_n = 1'b1;
        drive(16'hEEEE, 2'b10, 1'b1, 4'd4, 16'h0000);
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== {1'b1, 16'hEEEE, 4'd4, 2'b10, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL midreset_push got %h want %h", obs(), {1'b1, 16'hEEEE, 4'd4, 2'b10, 1'b0, 2'd1});
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(16'h0100, 2'b01, 1'b1, 4'd0, 16'h0000);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(16'h0101 + 16'(i), 2'b01, 1'b1, 4'(i + 1), 16'h0000);
            tick();
            checks++;
            if ({level, out_data, out_cnt} !== {2'd1, 16'h0101 + 16'(i), 4'(i + 1)}) begin
                errors++;
                $display("FAIL b2b_%0d got %h want %h", i, {level, out_data, out_cnt},
                         {2'd1, 16'h0101 + 16'(i), 4'(i + 1)});
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, level} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_drain got %b want 000", {out_valid, level});
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_op      = '0;
        in_imm_sel = 1'b0;
        in_imm     = '0;
        in_reg_cnt = '0;
        out_ready  = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_saturation();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
